// File: rtl/regs_wb_scoreboard.sv
// regs_wb_scoreboard
//   Arbitrates the single register-file write port between the pipeline
//   write-back stage (always wins) and a multi-cycle long unit (mul/div).
//   Long-unit results that cannot be written immediately wait in a small
//   FIFO. A per-register counter tracks outstanding long-latency writes and
//   drives a RAW/WAW stall towards the decode stage.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   issue_valid_i/waddr_i/ready_o  long-op issue handshake (bumps scoreboard)
//   lu_valid_i/waddr_i/wrdata_i    long-unit result, accepted when lu_ready_o
//   wb_we_i/waddr_i/wrdata_i       pipeline write-back, never back-pressured
//   rf_we_o/waddr_o/wrdata_o       register-file write port
//   regs_raddr_i                   decode read addresses (RAW check)
//   dec_we_i/dec_waddr_i           decode destination (WAW check)
//   stall_o                        hold decode
//   pending_o                      per-register "write outstanding" flags
module regs_wb_scoreboard #(
    parameter int READ_PORTS = 2,
    parameter int BUF_DEPTH  = 2,
    parameter int PEND_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid_i,
    input  logic [4:0]                 issue_waddr_i,
    output logic                       issue_ready_o,
    input  logic                       lu_valid_i,
    input  logic [4:0]                 lu_waddr_i,
    input  logic [31:0]                lu_wrdata_i,
    output logic                       lu_ready_o,
    input  logic                       wb_we_i,
    input  logic [4:0]                 wb_waddr_i,
    input  logic [31:0]                wb_wrdata_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [31:0]                rf_wrdata_o,
    input  logic [READ_PORTS-1:0][4:0] regs_raddr_i,
    input  logic                       dec_we_i,
    input  logic [4:0]                 dec_waddr_i,
    output logic                       stall_o,
    output logic [31:0]                pending_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_cnt [32];
    logic [4:0]        fifo_addr [BUF_DEPTH];
    logic [31:0]       fifo_data [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic       wb_sel;
    logic       fifo_empty;
    logic       pop;
    logic       bypass;
    logic       push;
    logic       lu_accept;
    logic       lu_dec;
    logic [4:0] dec_addr;
    logic       issue_fire;
    logic       raw_hit;
    logic       waw_hit;

    assign fifo_empty = (fifo_cnt == '0);
    assign wb_sel     = wb_we_i && (wb_waddr_i != 5'd0);
    // Queued results drain before a new one may bypass, keeping result order.
    assign pop        = !wb_sel && !fifo_empty;
    assign bypass     = !wb_sel && fifo_empty && lu_valid_i && (lu_waddr_i != 5'd0);

    // Ready depends only on registered FIFO occupancy, never on wb_we_i.
    assign lu_ready_o = rst_n && (fifo_cnt != FULL_CNT);
    assign lu_accept  = lu_valid_i && lu_ready_o;
    // r0 results are consumed and dropped: they would never reach the port.
    assign push       = lu_accept && !bypass && (lu_waddr_i != 5'd0);

    assign lu_dec     = pop || bypass;
    assign dec_addr   = pop ? fifo_addr[rd_ptr] : lu_waddr_i;

    assign issue_ready_o = rst_n && ((issue_waddr_i == 5'd0) ||
                                     (pend_cnt[issue_waddr_i] != PEND_MAX));
    assign issue_fire    = issue_valid_i && issue_ready_o && (issue_waddr_i != 5'd0);

    always_comb begin
        rf_we_o     = 1'b0;
        rf_waddr_o  = 5'd0;
        rf_wrdata_o = 32'd0;
        if (wb_sel) begin
            rf_we_o     = rst_n;
            rf_waddr_o  = wb_waddr_i;
            rf_wrdata_o = wb_wrdata_i;
        end else if (pop) begin
            rf_we_o     = rst_n;
            rf_waddr_o  = fifo_addr[rd_ptr];
            rf_wrdata_o = fifo_data[rd_ptr];
        end else if (bypass) begin
            rf_we_o     = rst_n;
            rf_waddr_o  = lu_waddr_i;
            rf_wrdata_o = lu_wrdata_i;
        end
    end

    // FIFO control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    // FIFO storage, validity is carried by fifo_cnt
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_waddr_i;
            fifo_data[wr_ptr] <= lu_wrdata_i;
        end
    end

    // Scoreboard: decrement happens when the result hits the RF port, so the
    // stall clears exactly when a read would return the new value. r0 never
    // matches issue_fire or lu_dec and therefore stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (issue_fire && (issue_waddr_i == 5'(r)) &&
                    !(lu_dec && (dec_addr == 5'(r))))
                    pend_cnt[r] <= pend_cnt[r] + PEND_W'(1);
                else if (lu_dec && (dec_addr == 5'(r)) &&
                         !(issue_fire && (issue_waddr_i == 5'(r))))
                    pend_cnt[r] <= pend_cnt[r] - PEND_W'(1);
            end
        end
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if ((regs_raddr_i[i] != 5'd0) && (pend_cnt[regs_raddr_i[i]] != '0))
                raw_hit = 1'b1;
        end
        waw_hit = dec_we_i && (dec_waddr_i != 5'd0) && (pend_cnt[dec_waddr_i] != '0);
        stall_o = raw_hit || waw_hit;
    end

    always_comb begin
        pending_o = 32'd0;
        for (int r = 0; r < 32; r++) pending_o[r] = (pend_cnt[r] != '0);
    end

    // A long-unit write for a register with nothing outstanding means the
    // issue/result protocol was broken upstream.
    dec_never_underflows: assert property (
        @(posedge clk) disable iff (!rst_n) lu_dec |-> (pend_cnt[dec_addr] != '0));

endmodule
